// File: rtl/uart_receiver.sv
// 8N1 UART receiver: 2-flop input synchronizer, mid-bit sampling FSM and a
// hold-until-acknowledged byte output with sticky overrun flag.
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | line idle, waiting for a low level on rx_s
// START     | half-bit wait, then confirm the start bit is still low
// DATA      | sample 8 data bits at mid-bit, LSB first
// STOP      | sample stop bit at mid-bit
// DELIVER   | one cycle: publish byte, update data_ready / overrun
// WAIT_IDLE | after a framing error, wait for the line to return high
module uart_receiver #(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       serial_in,
    input  logic       read_ack,
    output logic [7:0] data_received,
    output logic       data_ready,
    output logic       receiving,
    output logic       frame_error,
    output logic       overrun
);

    localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_DELIVER,
        S_WAIT_IDLE
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  data_q, data_d;
    logic        data_ready_q, data_ready_d;
    logic        frame_error_q, frame_error_d;
    logic        overrun_q, overrun_d;
    logic        rx_meta_q, rx_s_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= serial_in;
            rx_s_q    <= rx_meta_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            idx_q         <= '0;
            shift_q       <= '0;
            data_q        <= '0;
            data_ready_q  <= 1'b0;
            frame_error_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            shift_q       <= shift_d;
            data_q        <= data_d;
            data_ready_q  <= data_ready_d;
            frame_error_q <= frame_error_d;
            overrun_q     <= overrun_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        idx_d         = idx_q;
        shift_d       = shift_q;
        data_d        = data_q;
        data_ready_d  = data_ready_q;
        frame_error_d = 1'b0;
        overrun_d     = overrun_q;

        if (read_ack && data_ready_q) begin
            data_ready_d = 1'b0;
            overrun_d    = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (!rx_s_q) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end
            end
            S_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    idx_d = '0;
                    state_d = rx_s_q ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_s_q;
                    if (idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        state_d = S_DELIVER;
                    end else begin
                        frame_error_d = 1'b1;
                        state_d       = S_WAIT_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_DELIVER: begin
                // An ack landing this cycle retires the old byte, so it blocks overrun.
                data_d       = shift_q;
                data_ready_d = 1'b1;
                if (data_ready_q && !read_ack) begin
                    overrun_d = 1'b1;
                end
                state_d = S_IDLE;
            end
            S_WAIT_IDLE: begin
                if (rx_s_q) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign data_received = data_q;
    assign data_ready    = data_ready_q;
    assign receiving     = (state_q != S_IDLE);
    assign frame_error   = frame_error_q;
    assign overrun       = overrun_q;

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- Serial-to-parallel receiver for the UART link: recovers 8N1 frames from `serial_in` and presents each byte on a hold-until-acknowledged interface.
- Frame format: 1 start bit (low), 8 data bits LSB first, 1 stop bit (high); line idles high.
- Runs on the system clock and derives bit timing from an internal counter.
- Sits between the board RX pin and the command/decoder logic that consumes received bytes.

Parameters:
- `CLKS_PER_BIT`, 434, system clock cycles per serial bit (50 MHz / 115200). Legal range 4..65535. Counter width is 16 bits.

Ports:
- `clk`  input  1  system clock, rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `serial_in`  input  1  asynchronous serial line, idle high.
- `read_ack`  input  1  consumer pulse; clears `data_ready`.
- `data_received`  output  8  last good byte; stable while `data_ready`=1.
- `data_ready`  output  1  byte available; held until `read_ack`.
- `receiving`  output  1  high in every state except IDLE.
- `frame_error`  output  1  one-cycle pulse when the stop bit samples low.
- `overrun`  output  1  sticky; set when a good byte completes while `data_ready`=1. Cleared by `read_ack`.

Behaviour:
- Reset (asynchronous, any time, including mid-frame):
  - state=IDLE; counter=0; bit index=0; shift register=0.
  - Synchronizer flops=1.
  - `data_received`=8'h00; `data_ready`=0; `receiving`=0; `frame_error`=0; `overrun`=0.
- Input conditioning: `serial_in` passes through a 2-flop synchronizer. All logic uses the synchronized value `rx_s`; all latencies below count from `rx_s`.
- State machine:
  - IDLE: on `rx_s`=0, go to START and clear the counter.
  - START: count to CLKS_PER_BIT/2 - 1 (integer division), then resample.
    - `rx_s`=1: false start; return to IDLE with no outputs.
    - `rx_s`=0: go to DATA with counter=0 and bit index=0.
  - DATA: count to CLKS_PER_BIT-1, then sample `rx_s` into `shift[idx]` (LSB first).
    - idx=7: go to STOP; otherwise increment idx.
    - Each sample falls one bit period after the previous one, i.e. at mid-bit.
  - STOP: count to CLKS_PER_BIT-1, then sample.
    - `rx_s`=1: good frame; go to DELIVER.
    - `rx_s`=0: pulse `frame_error` for one cycle, discard the byte, go to WAIT_IDLE.
  - DELIVER (one cycle):
    - `data_received` <= shift; `data_ready` <= 1.
    - If `data_ready` was already 1 and `read_ack`=0 this cycle, set `overrun`. The new byte still overwrites `data_received`.
    - Go to IDLE.
  - WAIT_IDLE: remain until `rx_s`=1, then go to IDLE. This prevents a break or stuck-low line from retriggering.
- Latency: `data_ready` rises 2 clocks after the stop-bit mid-sample.
- `read_ack` behaviour:
  - Clears `data_ready` and `overrun` on the next edge.
  - Ignored when `data_ready`=0.
  - `read_ack` in the same cycle as DELIVER: the ack applies to the old byte. `data_ready` stays 1 for the new byte and `overrun` is not set.
- Back-to-back frames: a start edge is accepted on the first IDLE cycle after DELIVER. No mandatory idle time beyond the stop bit.
- `frame_error` and `data_ready` never assert for the same frame.

Test Plan (`CLKS_PER_BIT`=8):
1. Send 8'hA5 as a clean frame, then assert `read_ack` 3 cycles after `data_ready` rises -> `data_ready`=1 with `data_received`=8'hA5, `frame_error`=0, `overrun`=0. After the ack, `data_ready`=0.
2. Drive a 3-cycle low glitch on an idle line -> state returns to IDLE, no `data_ready`, no `frame_error`, `receiving` falls within 6 cycles.
3. Send 8'h3C with the stop bit driven low, line held low 20 more cycles, then a clean 8'h81 -> `frame_error` pulses exactly once. No retrigger while the line is low. Then `data_received`=8'h81 with `data_ready`=1.
4. Send 8'h11 then 8'h22 back-to-back with no ack -> `overrun`=1, `data_received`=8'h22, `data_ready`=1. `read_ack` clears both flags.
5. Assert `reset` mid-frame after 4 data bits of 8'hFF -> all outputs zero immediately (asynchronous). A following clean 8'h5A is received correctly.
6. Send 8'h00 and then 8'hFF with `read_ack` timed to coincide with the second DELIVER cycle -> `overrun`=0, `data_ready`=1, `data_received`=8'hFF.
